// File: rtl/alu_core_pkg.sv
// Shared opcode constants, divider state encoding and opcode-class helpers for alu_core.
// The iterative divider is built only when ALU_CORE_DIV_EN is defined.
package alu_core_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } div_state_t;

  // Address-generating ops (ld/st/br) share the adder with add/addi.
  function automatic logic is_add_class(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LD) ||
           (op == OP_LDI) || (op == OP_ST) || (op == OP_BR);
  endfunction

  function automatic logic is_and_class(input logic [4:0] op);
    return (op == OP_AND) || (op == OP_ANDI);
  endfunction

endpackage

// File: rtl/alu_core_div.sv
// Iterative signed divider: restoring shift/subtract on magnitudes, one quotient bit
// per cycle (IDLE -> DIV x32 -> FIX -> IDLE); quotient/remainder are valid while done=1.
module alu_core_div
  import alu_core_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              busy,
  output logic              done
);

  div_state_t        state, next_state;
  logic [4:0]        count;
  logic [DATA_W-1:0] dvsr;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic              neg_q;
  logic              neg_r;
  logic              dvsr_zero;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;

  assign a_mag = dividend[DATA_W-1] ? -dividend : dividend;
  assign b_mag = divisor[DATA_W-1]  ? -divisor  : divisor;
  assign trial = {rem, quo[DATA_W-1]};
  assign diff  = trial - {1'b0, dvsr};

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_DIV;
      S_DIV:   if (count == 5'd31) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // quo starts as the dividend magnitude and is shifted out as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (clr) begin
      count     <= '0;
      dvsr      <= '0;
      quo       <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvsr_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count     <= '0;
            dvsr      <= b_mag;
            quo       <= a_mag;
            rem       <= '0;
            neg_q     <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
            neg_r     <= dividend[DATA_W-1];
            dvsr_zero <= (divisor == '0);
          end
        end
        S_DIV: begin
          count <= count + 5'd1;
          if (!diff[DATA_W]) begin
            rem <= diff[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b1};
          end else begin
            rem <= trial[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  // A zero divisor leaves rem = |A|, so the sign fix restores A; only the quotient is forced.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_FIX);
    quotient  = '0;
    remainder = '0;
    if (state == S_FIX) begin
      quotient  = dvsr_zero ? '1 : (neg_q ? -quo : quo);
      remainder = neg_r ? -rem : rem;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Clocked ALU core: single-cycle add/AND inline, signed divide in alu_core_div.
// Define ALU_CORE_DIV_EN to build the divider; otherwise opcode div acts as unknown.
module alu_core
  import alu_core_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [4:0]        opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [RES_W-1:0]  C,
  output logic              cout,
  output logic              busy,
  output logic              done
);

  logic            accept;
  logic            is_div_op;
  logic [DATA_W:0] sum;
  logic            div_done;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;

  assign accept = start && !busy;
  assign sum    = {1'b0, A} + {1'b0, B};

`ifdef ALU_CORE_DIV_EN
  logic div_busy;

  assign is_div_op = (opcode == OP_DIV);
  assign busy      = div_busy;

  alu_core_div u_div (
    .clk       (clk),
    .clr       (clr),
    .start     (accept && is_div_op),
    .dividend  (A),
    .divisor   (B),
    .quotient  (div_q),
    .remainder (div_r),
    .busy      (div_busy),
    .done      (div_done)
  );
`else
  assign is_div_op = 1'b0;
  assign busy      = 1'b0;
  assign div_done  = 1'b0;
  assign div_q     = '0;
  assign div_r     = '0;
`endif

  // accept and div_done are exclusive: div_done only occurs while busy is high.
  always_ff @(posedge clk) begin
    if (clr) begin
      C    <= '0;
      cout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && !is_div_op) begin
        done <= 1'b1;
        if (is_add_class(opcode)) begin
          C    <= {{(RES_W-DATA_W){1'b0}}, sum[DATA_W-1:0]};
          cout <= sum[DATA_W];
        end else if (is_and_class(opcode)) begin
          C    <= {{(RES_W-DATA_W){1'b0}}, A & B};
          cout <= 1'b0;
        end else begin
          C    <= '0;
          cout <= 1'b0;
        end
      end
      if (div_done) begin
        C    <= {div_r, div_q};
        cout <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core: single-cycle ops, signed divide timing/corners,
// busy-ignore and clr abort; covers both ALU_CORE_DIV_EN builds.
module tb_alu_core;
  import alu_core_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] C;
  logic        cout;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_core dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .opcode (opcode),
    .A      (A),
    .B      (B),
    .C      (C),
    .cout   (cout),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    opcode = op;
    A      = a;
    B      = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // lat = edges after the start edge at which done was seen (0 if never within budget).
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit saw_done;

    clr    = 1'b1;
    start  = 1'b0;
    opcode = '0;
    A      = '0;
    B      = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    check("reset_c", C, 64'h0);
    check("reset_cout", {63'b0, cout}, 64'h0);
    check("reset_busy", {63'b0, busy}, 64'h0);
    check("reset_done", {63'b0, done}, 64'h0);

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_c", C, 64'h0000_0000_8000_0000);
    check("add_ovf_cout", {63'b0, cout}, 64'h0);
    check("add_ovf_done", {63'b0, done}, 64'h1);
    @(negedge clk);
    check("add_done_pulse", {63'b0, done}, 64'h0);
    check("c_holds", C, 64'h0000_0000_8000_0000);

    issue(OP_ADDI, 32'hFFFF_FFFF, 32'h1);
    check("add_carry_c", C, 64'h0);
    check("add_carry_cout", {63'b0, cout}, 64'h1);

    issue(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and_c", C, 64'h0000_0000_00F0_00F0);
    check("and_cout", {63'b0, cout}, 64'h0);

    issue(OP_LD, 32'h10, 32'h4);
    check("ld_c", C, 64'h14);

    issue(OP_SUB, 32'h9, 32'h2);
    check("unknown_c", C, 64'h0);
    check("unknown_done", {63'b0, done}, 64'h1);

`ifdef ALU_CORE_DIV_EN
    issue(OP_DIV, 32'd100, 32'd7);
    check("div_busy_rise", {63'b0, busy}, 64'h1);
    A = $urandom;
    B = $urandom;
    wait_done(lat, busy_ok);
    check("div_pos_latency", 64'(lat), 64'd33);
    check("div_pos_busy_hold", {63'b0, busy_ok}, 64'h1);
    check("div_pos_c", C, 64'h0000_0002_0000_000E);
    check("div_pos_busy_fall", {63'b0, busy}, 64'h0);

    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    wait_done(lat, busy_ok);
    check("div_neg_latency", 64'(lat), 64'd33);
    check("div_neg_c", C, 64'hFFFF_FFFE_FFFF_FFF2);

    issue(OP_DIV, 32'd5, 32'd0);
    wait_done(lat, busy_ok);
    check("div_zero_latency", 64'(lat), 64'd33);
    check("div_zero_c", C, 64'h0000_0005_FFFF_FFFF);
    check("div_zero_cout", {63'b0, cout}, 64'h0);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, busy_ok);
    check("div_ovf_c", C, 64'h0000_0000_8000_0000);

    // Add issued mid-divide must be dropped.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    issue(OP_ADD, 32'h1, 32'h1);
    wait_done(lat, busy_ok);
    check("ignore_latency", 64'(lat + 5), 64'd33);
    check("ignore_c", C, 64'h0000_0002_0000_000E);

    // Back-to-back: add issued in the cycle busy has fallen.
    issue(OP_ADD, 32'h3, 32'h4);
    check("b2b_add_c", C, 64'h7);
    check("b2b_add_done", {63'b0, done}, 64'h1);

    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_abort_c", C, 64'h0);
    check("clr_abort_busy", {63'b0, busy}, 64'h0);
    check("clr_abort_done", {63'b0, done}, 64'h0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("clr_no_done", {63'b0, saw_done}, 64'h0);
`else
    issue(OP_ADD, 32'h5, 32'h6);
    issue(OP_DIV, 32'd100, 32'd7);
    check("nodiv_c", C, 64'h0);
    check("nodiv_done", {63'b0, done}, 64'h1);
    check("nodiv_busy", {63'b0, busy}, 64'h0);
    issue(OP_ADD, 32'h1, 32'h2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_c", C, 64'h0);
    check("clr_done", {63'b0, done}, 64'h0);
`endif

    issue(OP_ADD, 32'h1234_5678, 32'h1111_1111);
    check("post_clr_add_c", C, 64'h0000_0000_2345_6789);
    check("post_clr_add_done", {63'b0, done}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
